// File: rtl/seg_scan_mux_pkg.sv
// Shared constants and helpers for the six-digit multiplexed 7-segment display.
package seg_scan_mux_pkg;

    localparam int DIGITS = 6;
    localparam int SEG_W  = 8;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    // Vector that switches every digit common off for the given common polarity.
    function automatic logic [DIGITS-1:0] com_off(input logic active_low);
        return active_low ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    endfunction

endpackage

// File: rtl/seg_scan_mux_scan_prescaler.sv
// Slot prescaler: counts clk cycles within a digit slot and tracks the BLANK/DRIVE phase.
module scan_prescaler
    import seg_scan_mux_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic slot_end_o,
    output logic drive_phase_o
);

    localparam int               CNT_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_V    = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_V   = CNT_W'(BLANK_CYC);
    localparam bit               HAS_BLANK = (BLANK_CYC != 0);
    localparam phase_t           RST_PH    = HAS_BLANK ? PH_BLANK : PH_DRIVE;

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;
    logic             slot_end_s;
    phase_t           phase_q;

    // Next count: wrap at the end of the slot.
    always_comb begin
        slot_end_s = (div_cnt_q == LAST_V);
        if (slot_end_s) begin
            div_cnt_d = {CNT_W{1'b0}};
        end else begin
            div_cnt_d = div_cnt_q + CNT_W'(1);
        end
    end

    // Counter and phase FSM; phase always agrees with the registered count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= {CNT_W{1'b0}};
            phase_q   <= RST_PH;
        end else begin
            div_cnt_q <= div_cnt_d;
            case (phase_q)
                PH_BLANK: if (div_cnt_d == BLANK_V) phase_q <= PH_DRIVE;
                PH_DRIVE: if (slot_end_s && HAS_BLANK) phase_q <= PH_BLANK;
                default:  phase_q <= RST_PH;
            endcase
        end
    end

    assign slot_end_o    = slot_end_s;
    assign drive_phase_o = (phase_q == PH_DRIVE);

endmodule

// File: rtl/seg_scan_mux.sv
// Six-digit 7-segment scan driver: frame snapshot, digit sequencing and registered pin drive.
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int BLANK_CYC      = 16,
    parameter bit COM_ACTIVE_LOW = 1'b1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [SEG_W-1:0]  seg_data0,
    input  logic [SEG_W-1:0]  seg_data1,
    input  logic [SEG_W-1:0]  seg_data2,
    input  logic [SEG_W-1:0]  seg_data3,
    input  logic [SEG_W-1:0]  seg_data4,
    input  logic [SEG_W-1:0]  seg_data5,
    input  logic [DIGITS-1:0] digit_en,
    output logic [SEG_W-1:0]  seg_out,
    output logic [DIGITS-1:0] seg_com,
    output logic              frame_tick
);

    localparam logic [DIGITS-1:0] COM_OFF  = com_off(COM_ACTIVE_LOW);
    localparam logic [2:0]        LAST_DIG = 3'd5;

    logic [SEG_W-1:0]  seg_in_s [DIGITS];
    logic [SEG_W-1:0]  seg_snap_q [DIGITS];
    logic [DIGITS-1:0] en_snap_q;
    logic [2:0]        dig_q;
    logic [2:0]        dig_d;
    logic              slot_end_s;
    logic              drive_s;
    logic              frame_end_s;
    logic [DIGITS-1:0] onehot_s;
    logic [SEG_W-1:0]  seg_out_q;
    logic [SEG_W-1:0]  seg_out_d;
    logic [DIGITS-1:0] seg_com_q;
    logic [DIGITS-1:0] seg_com_d;
    logic              frame_tick_q;

    assign seg_in_s[0] = seg_data0;
    assign seg_in_s[1] = seg_data1;
    assign seg_in_s[2] = seg_data2;
    assign seg_in_s[3] = seg_data3;
    assign seg_in_s[4] = seg_data4;
    assign seg_in_s[5] = seg_data5;

    scan_prescaler #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_prescaler (
        .clk_i         (clk_in),
        .rst_ni        (rst),
        .slot_end_o    (slot_end_s),
        .drive_phase_o (drive_s)
    );

    // Digit sequencing; the wrap from the last digit is the frame boundary.
    always_comb begin
        frame_end_s = slot_end_s && (dig_q == LAST_DIG);
        if (frame_end_s) begin
            dig_d = 3'd0;
        end else if (slot_end_s) begin
            dig_d = dig_q + 3'd1;
        end else begin
            dig_d = dig_q;
        end
    end

    // Next pin values from the current digit, phase and snapshot.
    always_comb begin
        onehot_s = {{(DIGITS-1){1'b0}}, 1'b1} << dig_q;
        if (drive_s && en_snap_q[dig_q]) begin
            seg_out_d = seg_snap_q[dig_q];
            seg_com_d = COM_ACTIVE_LOW ? ~onehot_s : onehot_s;
        end else begin
            seg_out_d = SEG_BLANK;
            seg_com_d = COM_OFF;
        end
    end

    // Digit index register.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            dig_q <= 3'd0;
        end else begin
            dig_q <= dig_d;
        end
    end

    // Frame snapshot: all digits and enables are captured together at the boundary.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                seg_snap_q[i] <= SEG_BLANK;
            end
            en_snap_q <= {DIGITS{1'b0}};
        end else if (frame_end_s) begin
            for (int i = 0; i < DIGITS; i++) begin
                seg_snap_q[i] <= seg_in_s[i];
            end
            en_snap_q <= digit_en;
        end
    end

    // Registered pins; reset turns every common off immediately.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            seg_out_q    <= SEG_BLANK;
            seg_com_q    <= COM_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            seg_out_q    <= seg_out_d;
            seg_com_q    <= seg_com_d;
            frame_tick_q <= frame_end_s;
        end
    end

    assign seg_out    = seg_out_q;
    assign seg_com    = seg_com_q;
    assign frame_tick = frame_tick_q;

endmodule
